// File: rtl/wb_pipelined_mem_if.sv
// Wishbone B4 pipelined bus bundle between a master and wb_pipelined_mem.
// Signal names keep the slave-side _i/_o suffixes so they read the same
// from either end.
interface wb_pipelined_mem_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 10
) ();
   logic [ADDR_WIDTH-1:0]   wb_adr_i;
   logic [DATA_WIDTH-1:0]   wb_dat_i;
   logic [DATA_WIDTH-1:0]   wb_dat_o;
   logic [DATA_WIDTH/8-1:0] wb_sel_i;
   logic                    wb_we_i;
   logic                    wb_stb_i;
   logic                    wb_cyc_i;
   logic                    wb_ack_o;
   logic                    wb_stall_o;

   modport master (
      output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      input  wb_dat_o, wb_ack_o, wb_stall_o
   );

   modport slave (
      input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
      output wb_dat_o, wb_ack_o, wb_stall_o
   );
endinterface

// File: rtl/wb_pipelined_mem.sv
// Pipelined Wishbone B4 slave RAM with byte-masked writes, a minimum ack
// latency and an in-order response queue of up to MAX_OUTSTANDING entries.
// stall_request_i / ack_hold_i let a bench inject back-pressure.
module wb_pipelined_mem #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 10,
   parameter int ACK_LATENCY     = 1,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   wb_pipelined_mem_if.slave                    wb,
   input  logic                                 stall_request_i,
   input  logic                                 ack_hold_i,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int AGE_W = $clog2(ACK_LATENCY + 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(ACK_LATENCY);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   // Response queue: slot 0 is always the head, entries shift down on pop.
   logic [DATA_WIDTH-1:0] qdata_q [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] qdata_d [MAX_OUTSTANDING];
   logic [AGE_W-1:0]      qage_q  [MAX_OUTSTANDING];
   logic [AGE_W-1:0]      qage_d  [MAX_OUTSTANDING];

   logic [CNT_W-1:0]      count_q, count_d;
   logic                  ack_q, ack_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;

   logic                  accept;
   logic                  pop;
   logic [DATA_WIDTH-1:0] push_data;
   logic [CNT_W-1:0]      wr_idx;

   // Full stalls even if an ack would free a slot at the same edge; keeps
   // the stall path free of the ack decision.
   assign wb.wb_stall_o = !rst_i || stall_request_i || (count_q == CNT_FULL);
   assign accept        = wb.wb_cyc_i && wb.wb_stb_i && !wb.wb_stall_o;

   // Head is ready when its age reaches ACK_LATENCY at this edge.
   assign pop = rst_i && wb.wb_cyc_i && !ack_hold_i && (count_q != '0) &&
                (int'(qage_q[0]) + 1 >= ACK_LATENCY);

   // Read is combinational from the array so a read right after a write to
   // the same word sees the committed data.
   assign push_data = wb.wb_we_i ? '0 : mem_q[wb.wb_adr_i];
   assign wr_idx    = pop ? count_q - CNT_W'(1) : count_q;

   assign wb.wb_ack_o   = ack_q;
   assign wb.wb_dat_o   = dat_q;
   assign outstanding_o = count_q;

   // Byte-masked write commit at the accept edge; contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept && wb.wb_we_i) begin
         for (int k = 0; k < SEL_W; k++) begin
            if (wb.wb_sel_i[k]) begin
               mem_q[wb.wb_adr_i][k*8 +: 8] <= wb.wb_dat_i[k*8 +: 8];
            end
         end
      end
   end

   // Queue next state: shift on pop, age every slot, then push at the tail.
   always_comb begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         qdata_d[i] = qdata_q[i];
         qage_d[i]  = qage_q[i];
      end
      if (pop) begin
         for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
            qdata_d[i] = qdata_q[i+1];
            qage_d[i]  = qage_q[i+1];
         end
      end
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
         if (qage_d[i] != AGE_MAX) begin
            qage_d[i] = qage_d[i] + AGE_W'(1);
         end
         if (accept && (i == int'(wr_idx))) begin
            qdata_d[i] = push_data;
            qage_d[i]  = '0;
         end
      end
   end

   // Ack, read data and outstanding count; dropping cyc aborts everything.
   always_comb begin
      count_d = count_q;
      ack_d   = 1'b0;
      dat_d   = dat_q;
      if (pop) begin
         ack_d = 1'b1;
         dat_d = qdata_q[0];
      end
      if (accept && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (!accept && pop) begin
         count_d = count_q - CNT_W'(1);
      end
      if (!wb.wb_cyc_i) begin
         count_d = '0;
         ack_d   = 1'b0;
      end
   end

   // Control registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         count_q <= '0;
         ack_q   <= 1'b0;
         dat_q   <= '0;
      end else begin
         count_q <= count_d;
         ack_q   <= ack_d;
         dat_q   <= dat_d;
      end
   end

   // Queue storage; stale slots are masked by count_q so no reset needed.
   always_ff @(posedge clk_i) begin
      qdata_q <= qdata_d;
      qage_q  <= qage_d;
   end
endmodule

// File: tb/tb_wb_pipelined_mem.sv
// Bench for wb_pipelined_mem: randomized and directed traffic checked against
// a transaction-level model (word array + FIFO of {data, accept edge}).
module tb_wb_pipelined_mem;
   localparam int DW  = 32;
   localparam int AW  = 6;
   localparam int L   = 2;
   localparam int MAX = 3;
   localparam int CW  = $clog2(MAX + 1);

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          stall_request_i;
   logic          ack_hold_i;
   logic [CW-1:0] outstanding_o;

   wb_pipelined_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   wb_pipelined_mem #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ACK_LATENCY(L), .MAX_OUTSTANDING(MAX)
   ) dut (
      .clk_i           (clk_i),
      .rst_i           (rst_i),
      .wb              (bus),
      .stall_request_i (stall_request_i),
      .ack_hold_i      (ack_hold_i),
      .outstanding_o   (outstanding_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference model state
   logic [DW-1:0] m_mem [1 << AW];
   logic [DW-1:0] q_data [$];
   int            q_edge [$];
   int            edge_n = 0;
   logic          exp_ack;
   logic [DW-1:0] exp_dat;
   int            exp_out;
   logic          exp_stall;
   bit            m_acc;

   int vec  = 0;
   int miss = 0;

   // Advance one clock edge and update the model from the inputs seen there.
   task automatic cycle();
      logic [DW-1:0] w;
      bit acc;
      acc = bus.wb_cyc_i && bus.wb_stb_i && rst_i && !stall_request_i &&
            (q_data.size() < MAX);
      @(posedge clk_i);
      edge_n++;
      m_acc = acc;
      if (!rst_i || !bus.wb_cyc_i) begin
         q_data.delete();
         q_edge.delete();
         exp_ack = 1'b0;
         if (!rst_i) exp_dat = '0;
      end else begin
         if (q_data.size() > 0 && (edge_n - q_edge[0]) >= L && !ack_hold_i) begin
            exp_ack = 1'b1;
            exp_dat = q_data.pop_front();
            void'(q_edge.pop_front());
         end else begin
            exp_ack = 1'b0;
         end
         if (acc) begin
            if (bus.wb_we_i) begin
               w = m_mem[bus.wb_adr_i];
               for (int k = 0; k < DW/8; k++)
                  if (bus.wb_sel_i[k]) w[k*8 +: 8] = bus.wb_dat_i[k*8 +: 8];
               m_mem[bus.wb_adr_i] = w;
               q_data.push_back('0);
            end else begin
               q_data.push_back(m_mem[bus.wb_adr_i]);
            end
            q_edge.push_back(edge_n);
         end
      end
      #1;
      exp_out   = q_data.size();
      exp_stall = !rst_i || stall_request_i || (q_data.size() == MAX);
   endtask

   task automatic drive(input logic cyc, input logic stb, input logic we,
                        input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [DW/8-1:0] sel);
      bus.wb_cyc_i = cyc;
      bus.wb_stb_i = stb;
      bus.wb_we_i  = we;
      bus.wb_adr_i = adr;
      bus.wb_dat_i = dat;
      bus.wb_sel_i = sel;
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (i == 3) rst_i = 1'b1;
         drive(i < 3, i < 3, 1'b0, AW'(i), '0, '1);
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL reset ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL reset dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL reset outstanding: got %0d want %0d", outstanding_o, exp_out); end
         vec++; if (bus.wb_stall_o !== exp_stall) begin miss++; $display("FAIL reset stall: got %b want %b", bus.wb_stall_o, exp_stall); end
      end
   endtask

   task automatic test_fill();
      for (int i = 0; i < (1 << AW) + L + 3; i++) begin
         drive(1'b1, i < (1 << AW), 1'b1, AW'(i), (i == 5) ? 32'hDEADBEEF : $urandom, '1);
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL fill ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL fill dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL fill outstanding: got %0d want %0d", outstanding_o, exp_out); end
         vec++; if (bus.wb_stall_o !== exp_stall) begin miss++; $display("FAIL fill stall: got %b want %b", bus.wb_stall_o, exp_stall); end
      end
   endtask

   task automatic test_single_read();
      int ack_at = -1;
      logic [DW-1:0] ack_dat = '0;
      for (int i = 1; i <= L + 3; i++) begin
         drive(1'b1, i == 1, 1'b0, AW'(5), '0, '0);
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL single ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL single dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL single outstanding: got %0d want %0d", outstanding_o, exp_out); end
         if (bus.wb_ack_o === 1'b1 && ack_at < 0) begin ack_at = i; ack_dat = bus.wb_dat_o; end
      end
      vec++; if (ack_at != L + 1) begin miss++; $display("FAIL single latency: got cycle %0d want %0d", ack_at, L + 1); end
      vec++; if (ack_dat !== 32'hDEADBEEF) begin miss++; $display("FAIL single data: got %h want deadbeef", ack_dat); end
   endtask

   task automatic test_burst();
      int first = -1, last = -1, acks = 0, stalls = 0;
      for (int i = 0; i < 8 + L + 3; i++) begin
         drive(1'b1, i < 8, 1'b0, AW'(i), '0, '0);
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL burst ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL burst dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL burst outstanding: got %0d want %0d", outstanding_o, exp_out); end
         if (bus.wb_stall_o === 1'b1 && i < 7) stalls++;
         if (bus.wb_ack_o === 1'b1) begin acks++; last = i; if (first < 0) first = i; end
      end
      vec++; if (stalls != 0) begin miss++; $display("FAIL burst stalls: got %0d want 0", stalls); end
      vec++; if (acks != 8 || first != L || last != L + 7) begin
         miss++; $display("FAIL burst ack train: got %0d acks at %0d..%0d want 8 at %0d..%0d", acks, first, last, L, L + 7);
      end
   endtask

   task automatic test_full_hold();
      ack_hold_i = 1'b1;
      for (int i = 0; i < 5 + L + 6; i++) begin
         if (i == 5) begin
            vec++; if (outstanding_o !== CW'(MAX) || bus.wb_stall_o !== 1'b1) begin
               miss++; $display("FAIL full state: got outstanding %0d stall %b want %0d 1", outstanding_o, bus.wb_stall_o, MAX);
            end
            ack_hold_i = 1'b0;
         end
         drive(1'b1, i < 7, 1'b0, AW'($urandom), '0, '0);
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL hold ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL hold dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL hold outstanding: got %0d want %0d", outstanding_o, exp_out); end
         vec++; if (bus.wb_stall_o !== exp_stall) begin miss++; $display("FAIL hold stall: got %b want %b", bus.wb_stall_o, exp_stall); end
      end
   endtask

   task automatic test_byte_sel();
      int acks = 0;
      logic [DW-1:0] rd = '0;
      for (int i = 0; i < 3 + L + 3; i++) begin
         case (i)
            0:       drive(1'b1, 1'b1, 1'b1, AW'(9), 32'h11223344, 4'b1111);
            1:       drive(1'b1, 1'b1, 1'b1, AW'(9), 32'hAABBCCDD, 4'b0101);
            2:       drive(1'b1, 1'b1, 1'b0, AW'(9), '0, '0);
            default: drive(1'b1, 1'b0, 1'b0, AW'(9), '0, '0);
         endcase
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL bytesel ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL bytesel dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         if (bus.wb_ack_o === 1'b1) begin acks++; if (acks == 3) rd = bus.wb_dat_o; end
      end
      vec++; if (rd !== 32'h11BB33DD) begin miss++; $display("FAIL bytesel readback: got %h want 11bb33dd", rd); end
   endtask

   task automatic test_abort(input bit use_reset);
      int late_acks = 0;
      for (int i = 0; i < 4 + L + 3; i++) begin
         ack_hold_i = (i < 3);
         rst_i      = !(use_reset && i == 3);
         drive(!(!use_reset && i == 3), i < 3, 1'b0, AW'($urandom), '0, '0);
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL abort ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL abort dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL abort outstanding: got %0d want %0d", outstanding_o, exp_out); end
         vec++; if (bus.wb_stall_o !== exp_stall) begin miss++; $display("FAIL abort stall: got %b want %b", bus.wb_stall_o, exp_stall); end
         if (i == 3) begin
            vec++; if (outstanding_o !== '0 || (use_reset && bus.wb_stall_o !== 1'b1)) begin
               miss++; $display("FAIL abort flush: got outstanding %0d stall %b", outstanding_o, bus.wb_stall_o);
            end
         end
         if (i >= 3 && bus.wb_ack_o === 1'b1) late_acks++;
      end
      rst_i = 1'b1;
      vec++; if (late_acks != 0) begin miss++; $display("FAIL abort late acks: got %0d want 0", late_acks); end
   endtask

   task automatic test_inject_stall();
      int dut_acks = 0, accepts = 0;
      for (int i = 0; i < 20 + L + 6; i++) begin
         stall_request_i = (i >= 5 && i < 9);
         drive(1'b1, i < 20, 1'b0, AW'($urandom), '0, '0);
         cycle();
         if (m_acc) accepts++;
         if (bus.wb_ack_o === 1'b1) dut_acks++;
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL stall ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL stall dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL stall outstanding: got %0d want %0d", outstanding_o, exp_out); end
         vec++; if (bus.wb_stall_o !== exp_stall) begin miss++; $display("FAIL stall stall: got %b want %b", bus.wb_stall_o, exp_stall); end
      end
      stall_request_i = 1'b0;
      vec++; if (dut_acks != accepts || accepts != 16) begin
         miss++; $display("FAIL stall ack count: got %0d acks for %0d accepts want 16 each", dut_acks, accepts);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst_i           = ($urandom_range(99) != 0);
         stall_request_i = ($urandom_range(99) < 15);
         ack_hold_i      = ($urandom_range(99) < 20);
         drive($urandom_range(99) >= 3, $urandom_range(99) < 70, $urandom_range(99) < 40,
               AW'($urandom), $urandom, (DW/8)'($urandom));
         cycle();
         vec++; if (bus.wb_ack_o !== exp_ack) begin miss++; $display("FAIL random ack: got %b want %b", bus.wb_ack_o, exp_ack); end
         vec++; if (bus.wb_dat_o !== exp_dat) begin miss++; $display("FAIL random dat: got %h want %h", bus.wb_dat_o, exp_dat); end
         vec++; if (outstanding_o !== CW'(exp_out)) begin miss++; $display("FAIL random outstanding: got %0d want %0d", outstanding_o, exp_out); end
         vec++; if (bus.wb_stall_o !== exp_stall) begin miss++; $display("FAIL random stall: got %b want %b", bus.wb_stall_o, exp_stall); end
      end
      rst_i = 1'b1; stall_request_i = 1'b0; ack_hold_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b0;
      stall_request_i = 1'b0;
      ack_hold_i = 1'b0;
      exp_ack = 1'b0;
      exp_dat = '0;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      test_reset();
      test_fill();
      test_single_read();
      test_burst();
      test_full_hold();
      test_byte_sel();
      test_abort(1'b0);
      test_abort(1'b1);
      test_inject_stall();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end
endmodule

// File: doc/wb_pipelined_mem.md
Name: wb_pipelined_mem

Overview:
Parametrised pipelined Wishbone B4 slave memory. It is the bench-side instruction/data memory behind fetch and load/store units, and a synthesizable on-chip RAM. It supports reads and byte-masked writes, configurable ack latency, and several outstanding requests. Stall and ack-hold inputs let benches inject back-pressure, so masters can be exercised under arbitrary bus timing.

Parameters:
DATA_WIDTH, 32, data bus width in bits; multiple of 8.
ADDR_WIDTH, 10, word-address width; memory depth is 2**ADDR_WIDTH words.
ACK_LATENCY, 1, minimum number of clock edges from request acceptance to ack; range 1..8.
MAX_OUTSTANDING, 4, maximum number of accepted but not-yet-acked requests; range 1..16.

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-low
wb_adr_i  in  ADDR_WIDTH  word address
wb_dat_i  in  DATA_WIDTH  write data
wb_dat_o  out  DATA_WIDTH  read data, valid while wb_ack_o is high
wb_sel_i  in  DATA_WIDTH/8  byte enables for writes
wb_we_i  in  1  1 = write, 0 = read
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle
wb_ack_o  out  1  acknowledge
wb_stall_o  out  1  pipeline stall
stall_request_i  in  1  injected stall (bench back-pressure)
ack_hold_i  in  1  suppresses ack emission this cycle
outstanding_o  out  $clog2(MAX_OUTSTANDING+1)  current outstanding count

Behaviour:
- Reset (rst_i=0 at an edge):
  - wb_ack_o=0, wb_dat_o=0, outstanding_o=0, response queue flushed.
  - Memory contents are not cleared.
  - wb_stall_o=1 whenever rst_i=0.
- Stall: wb_stall_o = !rst_i | stall_request_i | (count == MAX_OUTSTANDING). Combinational.
  - The full condition does not account for an ack popping in the same cycle, so full always stalls.
- Accept: at an edge where wb_cyc_i & wb_stb_i & !wb_stall_o are all high.
  - Write: bytes with wb_sel_i[k]=1 are committed to mem[wb_adr_i] at that edge. Unselected bytes are unchanged.
  - Read: mem[wb_adr_i] is sampled at that edge. A read accepted after a write to the same address observes the write, including in a back-to-back pipelined burst.
  - A queue entry {data, age=0} is pushed. Writes push a dummy entry with data=0.
- Queue: in-order FIFO, depth MAX_OUTSTANDING. Every entry's age increments each edge, saturating at ACK_LATENCY.
- Ack (registered):
  - At edge E, if the head entry's age reaches ACK_LATENCY at or before E, and ack_hold_i=0 at E, and wb_cyc_i=1, then wb_ack_o=1 and wb_dat_o=head data for the following cycle, and the head is popped. Otherwise wb_ack_o=0.
  - wb_dat_o holds its last value when not acking.
  - Request accepted at edge E0 gets its ack in the cycle after edge E0+ACK_LATENCY, at the earliest.
  - At most one ack per cycle; acks are strictly in acceptance order.
- Count: +1 on accept, -1 on ack, unchanged when both occur at the same edge. outstanding_o = count.
- Cycle abort: wb_cyc_i=0 at an edge flushes the queue, forces count=0 and wb_ack_o=0 next cycle. Writes already committed remain.
- Reset mid-burst: identical to abort, plus the reset values above; no ack is emitted after the reset edge.
- ack_hold_i: delays acks only; ages keep saturating; ordering is preserved.
- Throughput: with ACK_LATENCY=L, MAX_OUTSTANDING>=L+1, and no injected stalls or holds, one request is accepted and one acked every cycle.

Test Plan:
1. Single-read latency: ACK_LATENCY=1, mem[5]=0xDEADBEEF, read adr 5 accepted at edge 0 -> wb_ack_o=1 with wb_dat_o=0xDEADBEEF in cycle after edge 1 only; outstanding_o goes 1 then 0.
2. Pipelined burst: ACK_LATENCY=3, MAX_OUTSTANDING=4, reads of adr 0..7 on consecutive cycles -> no stall; acks on 8 consecutive cycles starting 3 edges after first accept; data in order.
3. Full and hold: MAX_OUTSTANDING=2, ack_hold_i=1, 3 reads issued -> wb_stall_o=1 after 2 accepts with outstanding_o=2. Release hold -> 2 acks in order, then third read accepted.
4. Byte-select write: mem[9]=0x11223344, write 0xAABBCCDD with sel=4'b0101, then read adr 9 back-to-back -> read returns 0x11BB33DD.
5. Abort and reset: 3 reads outstanding, wb_cyc_i=0 for one edge -> no acks and outstanding_o=0. Repeat with rst_i=0 -> same, plus wb_stall_o=1 during reset.
6. Injected stall: stall_request_i=1 for 4 cycles during a burst -> no accepts during those cycles; every request is acked exactly once, in order.
